// File: rtl/multi_tick_pkg.sv
// rtl/multi_tick_pkg.sv - mode codes and shared constants for multi_tick_divider
package multi_tick_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SQUARE  = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_ONESHOT = 2'd3
  } tickMode_e;

  // Smallest usable period; programmed divisors below this are raised to it.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/multi_tick_channel.sv
// rtl/multi_tick_channel.sv - one divider channel: counter, shadow config, pending/done flags
// and registered level/tick outputs.
module multi_tick_channel
  import multi_tick_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 6250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfgWrite,
  input  tickMode_e        cfgMode,
  input  logic [CNT_W-1:0] cfgDiv,
  input  logic [CNT_W-1:0] cfgHigh,
  output logic             pending,
  output logic             levelOut,
  output logic             tickPulse
);

  tickMode_e        mode, shMode;
  logic [CNT_W-1:0] cnt, div, high, shDiv, shHigh;
  logic             done;

  logic [CNT_W-1:0] divEff;
  logic             atWrap, shotDone, idle, applyNow, wave, tickNext;

  always_comb begin
    divEff   = (div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div;
    atWrap   = (cnt == divEff - CNT_W'(1));
    shotDone = (mode == MODE_ONESHOT) && done;
    idle     = !en || (mode == MODE_OFF) || shotDone;
    // A busy channel only takes new settings on its last cycle so the next period starts clean.
    applyNow = pending && (idle || atWrap);
    tickNext = en && atWrap && (mode != MODE_OFF) && !shotDone;
    wave     = 1'b0;
    case (mode)
      MODE_OFF:     wave = 1'b0;
      MODE_SQUARE:  wave = (cnt < (divEff >> 1));
      MODE_PWM:     wave = (cnt < high);
      MODE_ONESHOT: wave = !done;
      default:      wave = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      mode      <= MODE_SQUARE;
      div       <= CNT_W'(DEFAULT_DIV);
      high      <= CNT_W'(DEFAULT_DIV / 2);
      shMode    <= MODE_SQUARE;
      shDiv     <= CNT_W'(DEFAULT_DIV);
      shHigh    <= CNT_W'(DEFAULT_DIV / 2);
      pending   <= 1'b0;
      done      <= 1'b0;
      levelOut  <= 1'b0;
      tickPulse <= 1'b0;
    end else begin
      levelOut  <= en && wave;
      tickPulse <= tickNext;

      if ((mode == MODE_OFF) || shotDone) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= atWrap ? '0 : cnt + CNT_W'(1);
        if (atWrap && (mode == MODE_ONESHOT)) done <= 1'b1;
      end

      if (applyNow) begin
        mode    <= shMode;
        div     <= shDiv;
        high    <= shHigh;
        cnt     <= '0;
        done    <= 1'b0;
        pending <= 1'b0;
      end else if (cfgWrite) begin
        shMode  <= cfgMode;
        shDiv   <= cfgDiv;
        shHigh  <= cfgHigh;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_tick_divider.sv
// rtl/multi_tick_divider.sv - CHANNELS independent programmable clock dividers sharing one
// config write port.
module multi_tick_divider
  import multi_tick_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 6250000,
  localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_high,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] tick_pulse
);

  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] chanWrite;

  // Out-of-range channel numbers stay ready so such writes are swallowed.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CHAN_W'(i)) cfg_ready = !pending[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : gChan
    assign chanWrite[g] = cfg_valid && cfg_ready && (cfg_chan == CHAN_W'(g));

    multi_tick_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) uChannel (
      .clk      (clk),
      .reset    (reset),
      .en       (en[g]),
      .cfgWrite (chanWrite[g]),
      .cfgMode  (tickMode_e'(cfg_mode)),
      .cfgDiv   (cfg_div),
      .cfgHigh  (cfg_high),
      .pending  (pending[g]),
      .levelOut (level_out[g]),
      .tickPulse(tick_pulse[g])
    );
  end

endmodule

// File: tb/tb_multi_tick_divider.sv
// tb/tb_multi_tick_divider.sv - directed self-checking bench for multi_tick_divider
module tb_multi_tick_divider;
  import multi_tick_pkg::*;

  localparam int CH   = 5;
  localparam int W    = 24;
  localparam int DDIV = 10;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [1:0]    cfg_mode;
  logic [W-1:0]  cfg_div;
  logic [W-1:0]  cfg_high;
  logic [CH-1:0] level_out;
  logic [CH-1:0] tick_pulse;

  int nChecks = 0;
  int nPass   = 0;

  always #5 clk = ~clk;

  multi_tick_divider #(
    .CHANNELS   (CH),
    .CNT_W      (W),
    .DEFAULT_DIV(DDIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .level_out (level_out),
    .tick_pulse(tick_pulse)
  );

  task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else nPass++;
  endtask

  task automatic writeCfg(input int chan, input logic [1:0] mode, input logic [W-1:0] div,
                          input logic [W-1:0] high);
    int waitCnt;
    waitCnt   = 0;
    cfg_chan  = CW'(chan);
    cfg_mode  = mode;
    cfg_div   = div;
    cfg_high  = high;
    cfg_valid = 1'b1;
    #1;
    while (!cfg_ready && waitCnt < 100) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    if (!cfg_ready) expectEq("cfgReadyTimeout", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic sample(input int ch, input int n, output logic [31:0] lv,
                        output logic [31:0] tk, output logic [31:0] rd);
    lv = '0;
    tk = '0;
    rd = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      lv[k] = level_out[ch];
      tk[k] = tick_pulse[ch];
      rd[k] = cfg_ready;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] lv, tk, rd;
    logic [31:0] rdy;
    reset     = 1'b1;
    en        = '0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_mode  = MODE_OFF;
    cfg_div   = '0;
    cfg_high  = '0;
    repeat (3) @(negedge clk);
    expectEq("resetLevel", 32'(level_out), 32'h0);
    expectEq("resetTick", 32'(tick_pulse), 32'h0);
    expectEq("resetReady", 32'(cfg_ready), 32'd1);
    reset = 1'b0;

    // ch0 square, div 4
    writeCfg(0, MODE_SQUARE, 24'd4, 24'd0);
    expectEq("readyWhilePending", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    expectEq("readyAfterApply", 32'(cfg_ready), 32'd1);
    en[0] = 1'b1;
    sample(0, 8, lv, tk, rd);
    expectEq("sqDiv4Level", lv, 32'h33);
    expectEq("sqDiv4Tick", tk, 32'h88);

    // ch1 PWM div 5 high 2
    writeCfg(1, MODE_PWM, 24'd5, 24'd2);
    @(negedge clk);
    en[1] = 1'b1;
    sample(1, 10, lv, tk, rd);
    expectEq("pwmH2Level", lv, 32'h063);
    expectEq("pwmH2Tick", tk, 32'h210);

    // ch1 PWM high 0 and high 7
    en[1] = 1'b0;
    writeCfg(1, MODE_PWM, 24'd5, 24'd0);
    expectEq("enOffLevel", 32'(level_out[1]), 32'd0);
    expectEq("enOffTick", 32'(tick_pulse[1]), 32'd0);
    @(negedge clk);
    en[1] = 1'b1;
    sample(1, 10, lv, tk, rd);
    expectEq("pwmH0Level", lv, 32'h000);
    expectEq("pwmH0Tick", tk, 32'h210);
    en[1] = 1'b0;
    writeCfg(1, MODE_PWM, 24'd5, 24'd7);
    @(negedge clk);
    en[1] = 1'b1;
    sample(1, 10, lv, tk, rd);
    expectEq("pwmH7Level", lv, 32'h3FF);
    expectEq("pwmH7Tick", tk, 32'h210);

    // ch0 at div 8, rewrite to div 3 at cnt 2
    en[0] = 1'b0;
    writeCfg(0, MODE_SQUARE, 24'd8, 24'd0);
    @(negedge clk);
    en[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cfg_chan  = 3'd0;
    cfg_mode  = MODE_SQUARE;
    cfg_div   = 24'd3;
    cfg_high  = 24'd0;
    cfg_valid = 1'b1;
    #1;
    expectEq("midReadyBefore", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    sample(0, 12, lv, tk, rd);
    expectEq("midLevel", lv, 32'h243);
    expectEq("midTick", tk, 32'h920);
    expectEq("midReady", rd, 32'hFE0);

    // ch2 one-shot div 3, then restart
    writeCfg(2, MODE_ONESHOT, 24'd3, 24'd0);
    @(negedge clk);
    en[2] = 1'b1;
    sample(2, 8, lv, tk, rd);
    expectEq("shotLevel", lv, 32'h07);
    expectEq("shotTick", tk, 32'h04);
    writeCfg(2, MODE_ONESHOT, 24'd3, 24'd0);
    sample(2, 6, lv, tk, rd);
    expectEq("shotAgainLevel", lv, 32'h0E);
    expectEq("shotAgainTick", tk, 32'h08);

    // divisor clamp on ch3
    writeCfg(3, MODE_SQUARE, 24'd0, 24'd0);
    @(negedge clk);
    en[3] = 1'b1;
    sample(3, 6, lv, tk, rd);
    expectEq("div0Level", lv, 32'h15);
    expectEq("div0Tick", tk, 32'h2A);
    en[3] = 1'b0;
    writeCfg(3, MODE_SQUARE, 24'd1, 24'd0);
    @(negedge clk);
    en[3] = 1'b1;
    sample(3, 6, lv, tk, rd);
    expectEq("div1Level", lv, 32'h15);
    expectEq("div1Tick", tk, 32'h2A);

    // write to a nonexistent channel
    cfg_chan  = 3'd5;
    cfg_mode  = MODE_OFF;
    cfg_div   = 24'd9;
    cfg_valid = 1'b1;
    #1;
    expectEq("badChanReady", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    rdy = '0;
    for (int c = 0; c < CH; c++) begin
      cfg_chan = CW'(c);
      #1;
      rdy[c] = cfg_ready;
    end
    expectEq("badChanNoPending", rdy, 32'h1F);
    @(negedge clk);

    // reset with a pending write mid-count
    writeCfg(1, MODE_PWM, 24'd5, 24'd2);
    expectEq("pendingBeforeReset", 32'(cfg_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    expectEq("midResetLevel", 32'(level_out), 32'h0);
    expectEq("midResetTick", 32'(tick_pulse), 32'h0);
    expectEq("midResetReady", 32'(cfg_ready), 32'd1);
    en    = '1;
    reset = 1'b0;
    sample(0, 20, lv, tk, rd);
    expectEq("afterResetLevel", lv, 32'h07C1F);
    expectEq("afterResetTick", tk, 32'h80200);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
